weight_fetch_ctrl: RTL and testbench
====================================

Name: weight_fetch_ctrl

Overview:
- Read-side controller for the layer-1 weight ROM bank.
- Issues one-cycle read-enable pulses to all 28 ROMs in lockstep and waits out the ROM read latency.
- Captures the 28 parallel 16-bit weights into an output register and hands each weight vector to the downstream neuron array over a valid/ready handshake.
- One pass reads exactly DEPTH words, so the ROM internal address counters wrap back to word 0 at the end of every pass.

Parameters:
- NUM_NEURONS, 28: number of parallel ROMs / neurons.
- DATA_WIDTH, 16: width of one weight.
- DEPTH, 4: words per ROM per pass; equals 2**ADDR_WIDTH of the ROMs.
- ROM_LATENCY, 1: cycles from the r_en sampling edge to valid ROM data_out; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset; the same net also drives the ROM array.
- start  in  1  request one fetch pass; sampled only in IDLE.
- r_en  out  1  read enable to all ROMs; one-cycle pulse per word.
- rom_data  in  NUM_NEURONS*DATA_WIDTH  concatenated ROM outputs; ROM i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- w_data  out  NUM_NEURONS*DATA_WIDTH  captured weight vector, same packing as rom_data.
- w_idx  out  max(1,clog2(DEPTH))  word index of w_data, 0..DEPTH-1.
- w_valid  out  1  w_data/w_idx valid.
- w_ready  in  1  downstream accepts on w_valid && w_ready at the rising edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: state=IDLE; r_en=0; w_valid=0; w_data=0; w_idx=0; done=0; busy=0; word and latency counters=0. Reset overrides all other inputs.
- FSM states and transitions:
  - IDLE: go to ISSUE if start=1; otherwise stay.
  - ISSUE: one cycle; r_en=1 (a decode of the state, so high exactly during ISSUE); go to WAIT.
  - WAIT: lasts exactly ROM_LATENCY cycles. On the last WAIT edge, register rom_data into w_data, register the word counter into w_idx, set w_valid=1, go to HOLD.
  - HOLD: w_valid=1; w_data and w_idx held stable. On w_ready=1: clear w_valid. If word counter = DEPTH-1, reset the counter to 0 and go to DONE; otherwise increment the counter and go to ISSUE.
  - DONE: done=1 for this cycle only; busy=1; go to IDLE.
- Timing with ROM_LATENCY=1 and w_ready held high: start high in cycle s gives ISSUE at s+1, WAIT at s+2, w_valid at s+3. Each word takes 3 cycles. The last word is valid at s+12, done at s+13, and IDLE at s+14. In general each word takes 2+ROM_LATENCY cycles plus handshake stall cycles.
- Exactly DEPTH r_en pulses per pass; r_en is never asserted outside ISSUE.
- start while busy=1 (including DONE) is ignored and not queued. start in the cycle the FSM returns to IDLE starts a new pass.
- w_ready while w_valid=0 has no effect.
- Backpressure: HOLD lasts indefinitely; no further r_en is issued until acceptance.
- Reset mid-pass: everything returns to the reset values on the next edge. The ROMs share rst, so the next pass begins at word 0.
- No arithmetic on data; w_data is a pure register copy.

Test Plan:
- Basic pass: ROM words 0..3 of ROM i set to {i[7:0],8'h0k}; start pulse at cycle 0, w_ready=1 → w_valid at cycles 3, 6, 9, 12 with w_idx 0, 1, 2, 3; w_data slice i = {i,0k}; done at cycle 13; exactly 4 r_en pulses.
- Backpressure: w_ready=0 for 5 cycles while word 1 is valid → w_valid and w_data stay stable, no r_en during the stall; word 2 r_en appears the cycle after acceptance.
- start pulses at cycles 4 and 13 during a pass → ignored; exactly 4 r_en pulses and one done; busy drops at cycle 14.
- Back-to-back passes: start held high continuously → the second pass begins at cycle 14 with w_idx=0 and w_data equal to ROM word 0, confirming the ROM address wrap.
- Reset after word 2 is captured (w_valid=1) → next cycle w_valid=0, busy=0, w_data=0; a new start yields w_idx=0 with ROM word 0.
- ROM_LATENCY=2: start at cycle 0 → r_en at 1, first w_valid at 4, per-word period 4 cycles, done at cycle 17.

Source files
------------

// File: rtl/weight_fetch_if.sv
// Handshake and ROM-bank bundle between weight_fetch_ctrl and its surroundings.
// master is the controller side, slave is the ROM bank plus neuron-array side.
interface weight_fetch_if #(
    parameter int NUM_NEURONS = 28,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 4
);
    localparam int VEC_W = NUM_NEURONS * DATA_WIDTH;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Valid/ready: a word transfers on a rising edge where w_valid && w_ready;
    // once raised, w_valid stays high with w_data/w_idx frozen until that edge,
    // and w_ready seen while w_valid is low is ignored.
    logic             start;
    logic             r_en;
    logic [VEC_W-1:0] rom_data;
    logic [VEC_W-1:0] w_data;
    logic [IDX_W-1:0] w_idx;
    logic             w_valid;
    logic             w_ready;
    logic             busy;
    logic             done;
    logic [2:0]       fsm_state;

    modport master (
        input  start, rom_data, w_ready,
        output r_en, w_data, w_idx, w_valid, busy, done, fsm_state
    );

    modport slave (
        output start, rom_data, w_ready,
        input  r_en, w_data, w_idx, w_valid, busy, done, fsm_state
    );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// Read-side controller for the layer-1 weight ROM bank: pulses r_en once per
// word, waits out the ROM latency, and offers each captured vector downstream.
module weight_fetch_ctrl #(
    parameter int NUM_NEURONS = 28,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 4,
    parameter int ROM_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    weight_fetch_if.master bus
);
    localparam int VEC_W = NUM_NEURONS * DATA_WIDTH;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT_W = 3;
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(DEPTH - 1);
    localparam logic [LAT_W-1:0] LAST_WAIT = LAT_W'(ROM_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] word_cnt, word_cnt_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
    logic [VEC_W-1:0] data_q, data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            idx_q    <= '0;
            lat_cnt  <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            idx_q    <= idx_nxt;
            lat_cnt  <= lat_cnt_nxt;
            data_q   <= data_nxt;
        end
    end

    // The word counter mirrors the ROMs' internal address counters, so it only
    // advances on acceptance and wraps with them at the end of every pass.
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        idx_nxt      = idx_q;
        lat_cnt_nxt  = lat_cnt;
        data_nxt     = data_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_nxt = '0;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (lat_cnt == LAST_WAIT) begin
                    data_nxt    = bus.rom_data;
                    idx_nxt     = word_cnt;
                    lat_cnt_nxt = '0;
                    state_nxt   = HOLD;
                end else begin
                    lat_cnt_nxt = lat_cnt + LAT_W'(1);
                end
            end
            HOLD: begin
                if (bus.w_ready) begin
                    if (word_cnt == LAST_WORD) begin
                        word_cnt_nxt = '0;
                        state_nxt    = DONE;
                    end else begin
                        word_cnt_nxt = word_cnt + IDX_W'(1);
                        state_nxt    = ISSUE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // w_valid is high exactly while a captured word waits in HOLD.
    assign bus.r_en      = (state == ISSUE);
    assign bus.w_valid   = (state == HOLD);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.w_data    = data_q;
    assign bus.w_idx     = idx_q;
    assign bus.fsm_state = state;

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.w_valid && !bus.w_ready) |=> (bus.w_valid && $stable(bus.w_data) && $stable(bus.w_idx)));

    a_ren_pulse: assert property (@(posedge clk) disable iff (rst)
        bus.r_en |=> !bus.r_en);

    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        bus.done |=> (!bus.done && !bus.busy));

    a_ren_not_valid: assert property (@(posedge clk) disable iff (rst)
        !(bus.r_en && bus.w_valid));
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: ROM bank models, cycle tables, corner sequences,
// and a word-order reference model fed by random start/ready/reset traffic.
module tb_weight_fetch_ctrl;
    localparam int NN    = 28;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int NW    = NN * DW;
    localparam int EW    = NW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weight_fetch_if #(.NUM_NEURONS(NN), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();
    weight_fetch_if #(.NUM_NEURONS(NN), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus2 ();

    weight_fetch_ctrl #(.NUM_NEURONS(NN), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ROM_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus1));
    weight_fetch_ctrl #(.NUM_NEURONS(NN), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ROM_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    int total = 0;
    int bad   = 0;

    // ROM i, word k holds {i, k}.
    function automatic logic [NW-1:0] rom_vec(input int k);
        logic [NW-1:0] v;
        v = '0;
        for (int i = 0; i < NN; i++) v[i*DW +: DW] = {8'(i), 8'(k)};
        return v;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkv(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ROM bank models: internal address counter wraps at DEPTH, cleared by rst.
    logic [1:0]    rom1_addr;
    logic [NW-1:0] rom1_q;
    always @(posedge clk) begin
        if (rst) begin
            rom1_addr <= '0;
            rom1_q    <= '0;
        end else if (bus1.r_en) begin
            rom1_q    <= rom_vec(int'(rom1_addr));
            rom1_addr <= rom1_addr + 2'd1;
        end
    end
    assign bus1.rom_data = rom1_q;

    logic [1:0]    rom2_addr;
    logic [NW-1:0] rom2_s0, rom2_s1;
    always @(posedge clk) begin
        if (rst) begin
            rom2_addr <= '0;
            rom2_s0   <= '0;
            rom2_s1   <= '0;
        end else begin
            rom2_s1 <= rom2_s0;
            if (bus2.r_en) begin
                rom2_s0   <= rom_vec(int'(rom2_addr));
                rom2_addr <= rom2_addr + 2'd1;
            end
        end
    end
    assign bus2.rom_data = rom2_s1;

    // Reference model: a pass accepted from idle owes words 0..DEPTH-1 in order,
    // done follows the last acceptance, then the block is idle again.
    logic [EW-1:0] exp_q[$];
    bit model_en = 0;
    bit m_idle   = 1;
    bit m_done   = 0;
    int m_ren    = 0;

    always @(negedge clk) begin
        if (model_en) begin
            logic [EW-1:0] e;
            check1("m_busy", bus1.busy, !m_idle);
            check1("m_done", bus1.done, m_done);
            check1("m_ren_valid_overlap", bus1.r_en & bus1.w_valid, 1'b0);
            check1("m_ren_idle", bus1.r_en & m_idle, 1'b0);
            if (bus1.r_en) m_ren++;
            if (rst) begin
                exp_q.delete();
                m_idle = 1;
                m_done = 0;
                m_ren  = 0;
            end else if (m_done) begin
                m_done = 0;
                m_idle = 1;
            end else if (m_idle) begin
                if (bus1.start) begin
                    m_idle = 0;
                    m_ren  = 0;
                    for (int k = 0; k < DEPTH; k++) exp_q.push_back({2'(k), rom_vec(k)});
                end
            end else if (bus1.w_valid && bus1.w_ready) begin
                if (exp_q.size() == 0) begin
                    checki("m_extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkv("m_idx", NW'(bus1.w_idx), NW'(e[NW+1:NW]));
                    checkv("m_data", bus1.w_data, e[NW-1:0]);
                    if (exp_q.size() == 0) begin
                        m_done = 1;
                        checki("m_ren_count", m_ren, DEPTH);
                    end
                end
            end
        end
    end

    typedef struct {
        logic       start;
        logic       ready;
        logic       ren;
        logic       valid;
        logic [1:0] idx;
        logic       done;
        logic       busy;
    } vec_t;
    vec_t tbl[15];

    task automatic wait_idle1();
        int n = 0;
        while (bus1.busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check1("idle_timeout", bus1.busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [NW-1:0] held;
        // Basic pass with ignored start pulses at cycles 4 and 13.
        for (int c = 0; c < 15; c++) begin
            tbl[c].start = (c == 0 || c == 4 || c == 13);
            tbl[c].ready = 1'b1;
            tbl[c].ren   = (c == 1 || c == 4 || c == 7 || c == 10);
            tbl[c].valid = (c == 3 || c == 6 || c == 9 || c == 12);
            tbl[c].idx   = tbl[c].valid ? 2'((c - 3) / 3) : 2'd0;
            tbl[c].done  = (c == 13);
            tbl[c].busy  = (c >= 1 && c <= 13);
        end

        bus1.start = 1'b0; bus1.w_ready = 1'b0;
        bus2.start = 1'b0; bus2.w_ready = 1'b1;
        @(posedge clk); #1;
        model_en = 1;
        @(negedge clk);
        check1("rst_r_en", bus1.r_en, 1'b0);
        check1("rst_w_valid", bus1.w_valid, 1'b0);
        check1("rst_done", bus1.done, 1'b0);
        check1("rst_busy", bus1.busy, 1'b0);
        checkv("rst_w_data", bus1.w_data, '0);
        checkv("rst_w_idx", NW'(bus1.w_idx), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int c = 0; c < 15; c++) begin
            bus1.start   = tbl[c].start;
            bus1.w_ready = tbl[c].ready;
            @(negedge clk);
            check1("tbl_r_en", bus1.r_en, tbl[c].ren);
            check1("tbl_w_valid", bus1.w_valid, tbl[c].valid);
            check1("tbl_done", bus1.done, tbl[c].done);
            check1("tbl_busy", bus1.busy, tbl[c].busy);
            if (tbl[c].valid) begin
                checkv("tbl_w_idx", NW'(bus1.w_idx), NW'(tbl[c].idx));
                checkv("tbl_w_data", bus1.w_data, rom_vec(int'(tbl[c].idx)));
            end
            @(posedge clk); #1;
        end
        bus1.start = 1'b0;
        wait_idle1();

        // Backpressure: word 1 stalled for five cycles.
        held = '0;
        for (int c = 0; c < 14; c++) begin
            bus1.start   = (c == 0);
            bus1.w_ready = !(c >= 6 && c <= 10);
            @(negedge clk);
            if (c == 6) begin
                held = bus1.w_data;
                checkv("bp_first_data", bus1.w_data, rom_vec(1));
            end
            if (c >= 6 && c <= 11) begin
                check1("bp_valid", bus1.w_valid, 1'b1);
                checkv("bp_idx", NW'(bus1.w_idx), NW'(1));
                checkv("bp_data_stable", bus1.w_data, held);
                check1("bp_no_r_en", bus1.r_en, 1'b0);
            end
            if (c == 12) check1("bp_r_en_after_accept", bus1.r_en, 1'b1);
            @(posedge clk); #1;
        end
        bus1.start = 1'b0; bus1.w_ready = 1'b1;
        wait_idle1();

        // Back-to-back passes with start held high.
        for (int c = 0; c < 18; c++) begin
            bus1.start = 1'b1;
            @(negedge clk);
            if (c == 13) check1("b2b_done", bus1.done, 1'b1);
            if (c == 14) check1("b2b_idle", bus1.busy, 1'b0);
            if (c == 15) check1("b2b_r_en", bus1.r_en, 1'b1);
            if (c == 17) begin
                check1("b2b_valid", bus1.w_valid, 1'b1);
                checkv("b2b_idx", NW'(bus1.w_idx), '0);
                checkv("b2b_data", bus1.w_data, rom_vec(0));
            end
            @(posedge clk); #1;
        end
        bus1.start = 1'b0;
        wait_idle1();

        // Reset while word 2 is being offered, then a fresh pass.
        for (int c = 0; c < 14; c++) begin
            rst        = (c == 9);
            bus1.start = (c == 0 || c == 10);
            @(negedge clk);
            if (c == 9) begin
                check1("rr_valid_before", bus1.w_valid, 1'b1);
                checkv("rr_idx_before", NW'(bus1.w_idx), NW'(2));
            end
            if (c == 10) begin
                check1("rr_valid", bus1.w_valid, 1'b0);
                check1("rr_busy", bus1.busy, 1'b0);
                checkv("rr_data", bus1.w_data, '0);
                checkv("rr_idx", NW'(bus1.w_idx), '0);
            end
            if (c == 13) begin
                check1("rr_new_valid", bus1.w_valid, 1'b1);
                checkv("rr_new_idx", NW'(bus1.w_idx), '0);
                checkv("rr_new_data", bus1.w_data, rom_vec(0));
            end
            @(posedge clk); #1;
        end
        bus1.start = 1'b0;
        wait_idle1();

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 149) == 0);
            bus1.start   = ($urandom_range(0, 3) == 0);
            bus1.w_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; bus1.start = 1'b0; bus1.w_ready = 1'b1;
        wait_idle1();

        // Two-cycle ROM latency instance.
        for (int c = 0; c < 20; c++) begin
            bus2.start = (c == 0);
            @(negedge clk);
            check1("l2_r_en", bus2.r_en, (c == 1 || c == 5 || c == 9 || c == 13));
            check1("l2_valid", bus2.w_valid, (c == 4 || c == 8 || c == 12 || c == 16));
            check1("l2_done", bus2.done, (c == 17));
            if (c == 4 || c == 8 || c == 12 || c == 16) begin
                checkv("l2_idx", NW'(bus2.w_idx), NW'((c - 4) / 4));
                checkv("l2_data", bus2.w_data, rom_vec((c - 4) / 4));
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
